// File: rtl/mult_pkg.sv
// Shared types and sizing for the sequential shift-add multiplier.
package mult_pkg;

   localparam int MULT_N     = 32;
   localparam int MULT_CNT_W = $clog2(MULT_N) + 1;

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} mult_state_t;

endpackage

// File: rtl/add32.sv
// Combinational 32-bit ripple-carry adder used for the per-cycle partial-product add.
module add32
   import mult_pkg::*;
(
   input  logic [MULT_N-1:0] ina,
   input  logic [MULT_N-1:0] inb,
   input  logic              ci,
   output logic              co,
   output logic [MULT_N-1:0] out
);

   logic [MULT_N:0] carry;

   always_comb begin
      carry    = '0;
      out      = '0;
      carry[0] = ci;
      for (int i = 0; i < MULT_N; i++) begin
         out[i]       = ina[i] ^ inb[i] ^ carry[i];
         carry[i+1]   = (ina[i] & inb[i]) | (carry[i] & (ina[i] ^ inb[i]));
      end
      co = carry[MULT_N];
   end

endmodule

// File: rtl/seq_mult32.sv
// Unsigned N x N -> 2N shift-add multiplier, one partial-product add per clock.
// Optional early termination when the remaining multiplier bits are zero: SEQ_MULT_EARLY_TERM_EN.
//
// Handshake: a transfer happens on a rising edge where valid and ready are both 1.
// Upstream holds ina/inb/in_valid until in_ready; product and out_valid hold until out_ready.
module seq_mult32
   import mult_pkg::*;
#(
   parameter int N = MULT_N
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [N-1:0]  ina,
   input  logic [N-1:0]  inb,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [2*N-1:0] product,
   output logic          busy,
   output mult_state_t   state_o
);

   localparam int CNT_W = $clog2(N) + 1;

   mult_state_t    state_q;
   logic [N-1:0]   mcand_q;
   logic [2*N-1:0] p_q;
   logic [CNT_W-1:0] count_q;
   logic [2*N-1:0] product_q;
   logic           in_ready_q;
   logic           out_valid_q;
   logic           busy_q;

   logic [N-1:0]   add_b;
   logic [N-1:0]   add_sum;
   logic           add_co;
   logic [2*N-1:0] p_d;
   logic           finish_d;

   assign add_b = p_q[0] ? mcand_q : '0;

   add32 u_add32 (
      .ina (p_q[2*N-1:N]),
      .inb (add_b),
      .ci  (1'b0),
      .co  (add_co),
      .out (add_sum)
   );

`ifdef SEQ_MULT_EARLY_TERM_EN
   logic [N-1:0] lo_live;
   logic         lo_done;

   // Multiplier bits not yet consumed sit in lo[N-1-count:0].
   always_comb begin
      lo_live  = p_q[N-1:0] & ({N{1'b1}} >> count_q);
      lo_done  = (lo_live == '0);
      p_d      = lo_done ? (p_q >> (CNT_W'(N) - count_q))
                         : {add_co, add_sum, p_q[N-1:1]};
      finish_d = lo_done || (count_q == CNT_W'(N - 1));
   end
`else
   always_comb begin
      p_d      = {add_co, add_sum, p_q[N-1:1]};
      finish_d = (count_q == CNT_W'(N - 1));
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         mcand_q     <= '0;
         p_q         <= '0;
         count_q     <= '0;
         product_q   <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (in_valid) begin
                  mcand_q    <= ina;
                  p_q        <= {{N{1'b0}}, inb};
                  count_q    <= '0;
                  state_q    <= S_BUSY;
                  in_ready_q <= 1'b0;
                  busy_q     <= 1'b1;
               end
            end
            S_BUSY: begin
               p_q     <= p_d;
               count_q <= count_q + 1'b1;
               if (finish_d) begin
                  product_q   <= p_d;
                  state_q     <= S_DONE;
                  busy_q      <= 1'b0;
                  out_valid_q <= 1'b1;
               end
            end
            S_DONE: begin
               // in_ready only rises after this edge, so no accept shares the handoff cycle.
               if (out_ready) begin
                  state_q     <= S_IDLE;
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
               end
            end
            default: begin
               state_q     <= S_IDLE;
               in_ready_q  <= 1'b1;
               out_valid_q <= 1'b0;
               busy_q      <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign product   = product_q;
   assign busy      = busy_q;
   assign state_o   = state_q;

endmodule
